// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if
//   Bundles every non-clock signal of the register-file write arbiter.
//   master : the surrounding pipeline (drives WB/MCU requests, observes
//            the register-file write port and status).
//   slave  : the arbiter itself.
//   Signals:
//     wb_regwr/wb_wrreg/wb_data   write-back request, address, data
//     mc_valid/mc_wrreg/mc_data   MCU result, address, data
//     mc_ready                    MCU result FIFO not full
//     rf_we/rf_waddr/rf_wdata     registered register-file write port
//     pipe_stall                  one-cycle write-back bubble request
//     fifo_count                  queued MCU results
//     protocol_err                sticky: WB write seen during pipe_stall
//   Handshake: an MCU result transfers on a rising edge where
//   mc_valid && mc_ready; mc_valid may be held while mc_ready is low and
//   mc_ready never depends combinationally on mc_valid.
interface regfile_wr_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wb_regwr;
  logic [ADDR_W-1:0] wb_wrreg;
  logic [DATA_W-1:0] wb_data;
  logic              mc_valid;
  logic [ADDR_W-1:0] mc_wrreg;
  logic [DATA_W-1:0] mc_data;
  logic              mc_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              pipe_stall;
  logic [CW-1:0]     fifo_count;
  logic              protocol_err;

  modport master (
    output wb_regwr, wb_wrreg, wb_data, mc_valid, mc_wrreg, mc_data,
    input  mc_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, fifo_count,
           protocol_err
  );

  modport slave (
    input  wb_regwr, wb_wrreg, wb_data, mc_valid, mc_wrreg, mc_data,
    output mc_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, fifo_count,
           protocol_err
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Shares the single register-file write port between the write-back
//   stage and a multi-cycle unit. Write-back always wins; MCU results are
//   queued in a DEPTH-entry FIFO and drained into idle write-port cycles.
//   A starvation counter raises pipe_stall for one cycle so a queued MCU
//   result cannot lose arbitration forever.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    regfile_wr_arbiter_if.slave (see interface header)
module regfile_wr_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wr_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve;

  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              pipe_stall_q;
  logic              protocol_err_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic starve_hit;

  always_comb begin
    full  = (count == FULL_COUNT);
    empty = (count == '0);
    // Full is taken from the registered count, so a pop in a full cycle
    // only frees the slot for the following cycle.
    push  = bus.mc_valid && !full;
    pop   = !bus.wb_regwr && !empty;
    // The head has already lost MAX_WAIT-1 times and is about to lose again.
    starve_hit = bus.wb_regwr && !empty && (starve == STARVE_LIMIT);
  end

  // Payload storage carries no reset: occupancy is governed by head/tail/count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= bus.mc_wrreg;
      q_data[tail] <= bus.mc_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // When the FIFO is non-empty and nothing pops, WB was granted, so the
  // head lost this cycle. A pipe_stall cycle that WB ignores is just one
  // more lost grant, which restarts the count from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve       <= '0;
      pipe_stall_q <= 1'b0;
    end else begin
      pipe_stall_q <= starve_hit;
      if (empty || pop || starve_hit) starve <= '0;
      else                            starve <= starve + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (bus.wb_regwr) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= bus.wb_wrreg;
      rf_wdata_q <= bus.wb_data;
    end else if (pop) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= q_addr[head];
      rf_wdata_q <= q_data[head];
    end else begin
      rf_we_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) protocol_err_q <= 1'b0;
    else if (bus.wb_regwr && pipe_stall_q) protocol_err_q <= 1'b1;
  end

  assign bus.mc_ready     = !full;
  assign bus.fifo_count   = count;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.pipe_stall   = pipe_stall_q;
  assign bus.protocol_err = protocol_err_q;
endmodule
